instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
Fetch stage between the program counter register and the IF/ID boundary. Each cycle it:
- presents the current PC to instruction memory over a req/ack handshake;
- drives the next-PC value and the hold (stall) control into the program counter register;
- captures returned instructions into the IF/ID pipeline register, with a one-entry skid buffer for decode back-pressure;
- handles branch/jump redirects, including discarding responses that are already in flight.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width
PC_STEP, 4, sequential PC increment
NOP_INSTR, 32'h00000000, value loaded into ifid_instr on reset/flush

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (reset=0 resets)
pc  in  ADDR_W  current PC (program register Q)
pc_next  out  ADDR_W  program register D
pc_hold  out  1  program register en; 1 = hold PC, 0 = load pc_next
redirect  in  1  taken branch/jump from later stage, single-cycle pulse
redirect_pc  in  ADDR_W  redirect target
id_stall  in  1  decode not accepting IF/ID contents this cycle
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address
imem_ack  in  1  response valid, sampled only while imem_req=1
imem_rdata  in  DATA_W  instruction, valid with imem_ack
ifid_valid  out  1  IF/ID register holds a live instruction
ifid_instr  out  DATA_W  fetched instruction
ifid_pc  out  ADDR_W  address of ifid_instr
ifid_pc_plus4  out  ADDR_W  ifid_pc + PC_STEP

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE; ifid_valid=0; ifid_instr=NOP_INSTR; ifid_pc=0; ifid_pc_plus4=0; skid buffer empty; req_addr=0.
- Combinational outputs while reset=0: imem_req=0, pc_hold=1.
- pc_next = redirect ? redirect_pc : pc + PC_STEP. Arithmetic is modulo 2^ADDR_W, so 32'hFFFFFFFC + 4 wraps to 0.
- blocked = ifid_valid & id_stall.
- IF/ID update on every non-redirect edge: if id_stall=0, ifid_valid drops to 0 unless a new instruction loads that same edge.
- States:
  - IDLE: imem_req=0, pc_hold=1. Next state is FETCH unconditionally (one dead cycle after reset release).
  - FETCH: imem_req=1, imem_addr=pc; req_addr<=pc every cycle. pc stays stable because pc_hold=1 until ack.
    - ack & no redirect: pc_hold=0 (PC advances).
      - If not blocked: IF/ID <= {1, imem_rdata, pc, pc+PC_STEP}; stay FETCH. Back-to-back single-cycle acks give one instruction per cycle.
      - If blocked: skid <= {imem_rdata, pc}; go HOLD.
    - No ack & no redirect: pc_hold=1; stay FETCH.
  - HOLD: imem_req=0, pc_hold=1. When id_stall=0, IF/ID loads from skid (valid=1), skid empties, go FETCH.
  - DISCARD: imem_req=1, imem_addr=req_addr (the abandoned request stays stable until it completes), pc_hold=1. On ack, drop data and go FETCH.
- Redirect has priority over everything, including id_stall and ack. On the redirect edge:
  - pc_hold=0, so the PC loads redirect_pc;
  - ifid_valid<=0, ifid_instr<=NOP_INSTR;
  - skid is emptied.
- Redirect next-state by current state:
  - FETCH with ack the same cycle: data dropped; go FETCH.
  - FETCH without ack: go DISCARD.
  - HOLD: go FETCH.
  - DISCARD: stay DISCARD; if ack arrives the same cycle, go FETCH.
  - IDLE: go FETCH.
- Invariants:
  - At most one outstanding memory request at any time.
  - imem_addr never changes while imem_req=1 and no ack has been received.
  - An instruction is never written to IF/ID with a PC other than the one it was fetched from.
- Reset asserted mid-transaction drops all state immediately. The memory must tolerate the abandoned request.

Test Plan:
- Reset release with pc=0, zero-wait memory (ack same cycle), mem[i]=32'h1000_0000+i:
  - 1 IDLE cycle, then imem_addr = 0, 4, 8 on consecutive cycles;
  - IF/ID shows (32'h10000000, pc 0, plus4 4), then (32'h10000004, 4, 8);
  - pc_hold=0 each ack cycle.
- Memory latency 3 cycles at pc=32'h40:
  - imem_req high and imem_addr=32'h40 held for 3 cycles, pc_hold=1 throughout;
  - one pc_hold=0 pulse on the ack cycle; ifid_pc=32'h40.
- id_stall=1 for 4 cycles while an ack arrives:
  - instruction goes to skid, state HOLD, imem_req=0, ifid contents unchanged;
  - after id_stall drops, IF/ID shows the skid instruction, then fetch resumes. No instruction is lost or duplicated.
- Redirect to 32'h200 while a request for 32'h80 is outstanding (ack 2 cycles later):
  - ifid_valid=0 next edge, PC loads 32'h200;
  - imem_addr stays 32'h80 until ack, and that data is dropped;
  - the next request is for 32'h200.
- Redirect coinciding with ack and id_stall=1 from HOLD: skid discarded, ifid_valid=0, next fetch at redirect_pc.
- Assert reset=0 mid-fetch at pc=32'hFFFFFFFC:
  - all outputs reach reset values asynchronously;
  - after release, a fetch at 32'hFFFFFFFC yields pc_next=0 (wrap-around).

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: drives the PC register, talks to instruction memory
// over req/ack, and fills the IF/ID register through a one-entry skid buffer.
module instr_fetch_stage #(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          PC_STEP   = 4,
  parameter logic [DATA_W-1:0]    NOP_INSTR = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_hold,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t              state_q, state_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic [DATA_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0]   ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic                skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;

  logic                req_c;
  logic                hold_c;
  logic                ack;
  logic                blocked;
  logic [ADDR_W-1:0]   pc_plus_step;

  assign pc_plus_step = pc + STEP;
  assign pc_next      = redirect ? redirect_pc : pc_plus_step;
  assign blocked      = ifid_valid_q & id_stall;
  assign ack          = imem_ack & req_c;

  // Reset forces a quiet bus and a frozen PC regardless of the other inputs.
  assign imem_req      = reset & req_c;
  assign pc_hold       = ~reset | hold_c;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;

  always_comb begin
    state_d         = state_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    skid_valid_d    = skid_valid_q;
    skid_instr_d    = skid_instr_q;
    skid_pc_d       = skid_pc_q;
    req_addr_d      = req_addr_q;
    req_c           = 1'b0;
    hold_c          = 1'b1;
    imem_addr       = pc;

    // Decode consumes the IF/ID contents whenever it is not stalling.
    if (!id_stall) begin
      ifid_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        req_c      = 1'b1;
        req_addr_d = pc;
        if (ack) begin
          hold_c = 1'b0;
          if (!blocked) begin
            ifid_valid_d    = 1'b1;
            ifid_instr_d    = imem_rdata;
            ifid_pc_d       = pc;
            ifid_pc_plus4_d = pc_plus_step;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!id_stall) begin
          ifid_valid_d    = skid_valid_q;
          ifid_instr_d    = skid_instr_q;
          ifid_pc_d       = skid_pc_q;
          ifid_pc_plus4_d = skid_pc_q + STEP;
          skid_valid_d    = 1'b0;
          state_d         = FETCH;
        end
      end
      DISCARD: begin
        // Keep the abandoned address on the bus until memory answers it.
        req_c     = 1'b1;
        imem_addr = req_addr_q;
        if (ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect) begin
      hold_c       = 1'b0;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
      case (state_q)
        FETCH, DISCARD: state_d = ack ? FETCH : DISCARD;
        default:        state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      skid_valid_q    <= 1'b0;
      skid_instr_q    <= NOP_INSTR;
      skid_pc_q       <= '0;
      req_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      skid_valid_q    <= skid_valid_d;
      skid_instr_q    <= skid_instr_d;
      skid_pc_q       <= skid_pc_d;
      req_addr_q      <= req_addr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: plays PC register, instruction memory and decode,
// and checks the decoded stream against the sequential program order with redirects.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_next;
  logic        pc_hold;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .PC_STEP  (4),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .pc_next      (pc_next),
    .pc_hold      (pc_hold),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_stall     (id_stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus knobs
  int          lat_mode  = 0;   // <0: random latency 0..3, else fixed
  int          stall_pct = 0;
  int          redir_pct = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_target = 32'h0;

  // Memory model
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  bit          mem_abandon = 1'b0;

  // Program-order model
  logic [31:0] exp_pc = 32'h0;
  bit          prev_redir = 1'b0;
  bit          exp_req_valid = 1'b0;
  logic [31:0] exp_req_addr = 32'h0;
  int          idle_cnt = 0;

  // Last sampled cycle
  logic        req_s;
  logic [31:0] addr_s;
  logic        ack_s;
  logic        hold_s;
  logic [31:0] next_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic step();
    logic        rd;
    logic [31:0] rpc;
    @(negedge clk);
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    if (mem_busy) check("req_held", 32'(req_s), 32'd1);
    if (req_s) begin
      if (!mem_busy) begin
        mem_busy    = 1'b1;
        mem_cnt     = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        mem_addr    = addr_s;
        mem_abandon = 1'b0;
        if (exp_req_valid) begin
          check("req_after_redirect", addr_s, exp_req_addr);
          exp_req_valid = 1'b0;
        end
      end else begin
        check("addr_stable", addr_s, mem_addr);
      end
    end
    ack_s      = req_s && mem_busy && (mem_cnt == 0);
    imem_ack   = req_s ? ack_s : 1'($urandom_range(0, 1));
    imem_rdata = ack_s ? mem_word(mem_addr) : $urandom;
    id_stall   = (int'($urandom_range(0, 99)) < stall_pct);
    rd         = force_redir || (int'($urandom_range(0, 99)) < redir_pct);
    if (force_redir)                       rpc = force_target;
    else if ($urandom_range(0, 9) == 0)    rpc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
    else                                   rpc = 32'($urandom_range(0, 1023)) << 2;
    force_redir = 1'b0;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    check("pc_next", pc_next, rd ? rpc : pc + 32'd4);
    check("pc_hold", 32'(pc_hold), 32'(!(rd || (ack_s && !mem_abandon))));
    if (prev_redir) begin
      check("flush_valid", 32'(ifid_valid), 32'd0);
      check("flush_instr", ifid_instr, NOP);
    end
    if (!rd && ifid_valid && !id_stall) begin
      check("ifid_pc", ifid_pc, exp_pc);
      check("ifid_instr", ifid_instr, mem_word(exp_pc));
      check("ifid_pc_plus4", ifid_pc_plus4, exp_pc + 32'd4);
      $display("decode pc=%h instr=%h plus4=%h", ifid_pc, ifid_instr, ifid_pc_plus4);
      exp_pc   = exp_pc + 32'd4;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    if (idle_cnt > 200) begin
      check("progress_cycles", 32'(idle_cnt), 32'd0);
      idle_cnt = 0;
    end
    hold_s = pc_hold;
    next_s = pc_next;
    if (rd) begin
      exp_pc        = rpc;
      exp_req_valid = 1'b1;
      exp_req_addr  = rpc;
    end
    prev_redir = rd;
    @(posedge clk);
    #1;
    if (!hold_s) pc = next_s;
    if (ack_s) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt > 0) mem_cnt--;
      if (rd) mem_abandon = 1'b1;
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    redirect = 1'b1;
    reset    = 1'b0;
    #1;
    check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    check("rst_ifid_instr", ifid_instr, NOP);
    check("rst_ifid_pc", ifid_pc, 32'd0);
    check("rst_ifid_plus4", ifid_pc_plus4, 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_pc_hold", 32'(pc_hold), 32'd1);
    redirect      = 1'b0;
    imem_ack      = 1'b0;
    id_stall      = 1'b0;
    pc            = start_pc;
    mem_busy      = 1'b0;
    mem_abandon   = 1'b0;
    exp_pc        = start_pc;
    prev_redir    = 1'b0;
    exp_req_valid = 1'b0;
    idle_cnt      = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  logic [31:0] held_pc;

  initial begin
    // Zero-wait memory from pc=0
    lat_mode = 0;
    do_reset(32'h0);
    step();
    check("idle_req", 32'(req_s), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("zw_addr", addr_s, 32'(i * 4));
      check("zw_hold", 32'(hold_s), 32'd0);
    end
    repeat (3) step();

    // Three-cycle memory latency at 0x40
    lat_mode = 3;
    do_reset(32'h40);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("lat_addr", addr_s, 32'h40);
      check("lat_hold", 32'(hold_s), 32'd1);
    end
    step();
    check("lat_ack_hold", 32'(hold_s), 32'd0);
    step();
    check("lat_ifid_pc", ifid_pc, 32'h40);

    // Decode back-pressure into the skid buffer
    lat_mode = 0;
    repeat (4) step();
    stall_pct = 100;
    step();
    step();
    held_pc = ifid_pc;
    step();
    check("hold_req", 32'(req_s), 32'd0);
    step();
    check("hold_ifid_pc", ifid_pc, held_pc);
    stall_pct = 0;
    repeat (6) step();

    // Redirect while a request for 0x80 is outstanding
    lat_mode = 2;
    do_reset(32'h80);
    step();
    force_redir  = 1'b1;
    force_target = 32'h200;
    step();
    step();
    check("disc_addr", addr_s, 32'h80);
    step();
    check("disc_addr_ack", addr_s, 32'h80);
    check("disc_hold", 32'(hold_s), 32'd1);
    step();
    check("redir_addr", addr_s, 32'h200);
    repeat (3) step();

    // Redirect from HOLD while decode is stalled
    lat_mode = 0;
    repeat (3) step();
    stall_pct = 100;
    repeat (2) step();
    force_redir  = 1'b1;
    force_target = 32'h300;
    step();
    stall_pct = 0;
    step();
    check("hold_redir_addr", addr_s, 32'h300);
    repeat (3) step();

    // Asynchronous reset mid-fetch, then address wrap-around
    lat_mode = 3;
    do_reset(32'hFFFF_FFFC);
    step();
    step();
    do_reset(32'hFFFF_FFFC);
    lat_mode = 0;
    step();
    step();
    check("wrap_addr", addr_s, 32'hFFFF_FFFC);
    check("wrap_pc_next", next_s, 32'h0);
    repeat (3) step();

    // Randomized traffic
    lat_mode  = -1;
    stall_pct = 30;
    redir_pct = 5;
    repeat (3000) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
